// File: rtl/scan_sel_gen.sv
// ---------------------------------------------------------------------------
// scan_sel_gen
//   Time-multiplexed display scan generator. Each digit is selected for DIV
//   clock cycles. Between digits it drives BLANK cycles with every digit off,
//   which prevents ghosting while the downstream decoder switches. A
//   frame_done pulse marks each wrap-around of the digit index.
//
// Parameters
//   DIV   : cycles each digit is shown (1..65535)
//   BLANK : blanking cycles between digits (0..255)
//   NDIG  : number of digits scanned (1..8)
//
// Ports
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   en         : scan enable; dropping it parks the scanner in IDLE
//   clr        : synchronous restart from digit 0
//   dir        : scan direction (0 = up, 1 = down), used only at an advance
//   sel[2:0]   : current digit index (3-to-8 decoder select)
//   sel_vld    : digit addressed by sel may be driven (0 = all blanked)
//   frame_done : one-cycle pulse after an advance that wrapped
// ---------------------------------------------------------------------------
module scan_sel_gen #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2,
  parameter int NDIG  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       dir,
  output logic [2:0] sel,
  output logic       sel_vld,
  output logic       frame_done
);

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [7:0]  BLANK_LAST = (BLANK > 0) ? 8'(BLANK - 1) : 8'd0;
  localparam logic [2:0]  SEL_LAST   = 3'(NDIG - 1);
  localparam bit          HAS_BLANK  = (BLANK > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_BLANK
  } state_t;

  state_t      state_reg;
  logic [15:0] presc_reg;
  logic [7:0]  bcnt_reg;
  logic [2:0]  sel_reg;
  logic        sel_vld_reg;
  logic        frame_done_reg;

  // Index the scanner would move to if an advance happened this edge.
  logic [2:0] sel_next;
  logic       adv_wrap;

  always_comb begin
    adv_wrap = dir ? (sel_reg == 3'd0) : (sel_reg == SEL_LAST);
    if (dir) begin
      sel_next = adv_wrap ? SEL_LAST : sel_reg - 3'd1;
    end else begin
      sel_next = adv_wrap ? 3'd0 : sel_reg + 3'd1;
    end
  end

  // sel_vld is kept as its own register so it tracks the state entered on
  // the same edge without decoding state_reg combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      presc_reg      <= 16'd0;
      bcnt_reg       <= 8'd0;
      sel_reg        <= 3'd0;
      sel_vld_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (clr) begin
        // Restart wins over any advance that would have happened this edge.
        sel_reg     <= 3'd0;
        presc_reg   <= 16'd0;
        bcnt_reg    <= 8'd0;
        state_reg   <= en ? ST_SHOW : ST_IDLE;
        sel_vld_reg <= en;
      end else if (!en) begin
        // Abandon the current digit but keep its index for the resume.
        state_reg   <= ST_IDLE;
        presc_reg   <= 16'd0;
        bcnt_reg    <= 8'd0;
        sel_vld_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg   <= ST_SHOW;
            presc_reg   <= 16'd0;
            sel_vld_reg <= 1'b1;
          end
          ST_SHOW: begin
            if (presc_reg == DIV_LAST) begin
              sel_reg        <= sel_next;
              frame_done_reg <= adv_wrap;
              presc_reg      <= 16'd0;
              if (HAS_BLANK) begin
                state_reg   <= ST_BLANK;
                bcnt_reg    <= 8'd0;
                sel_vld_reg <= 1'b0;
              end else begin
                sel_vld_reg <= 1'b1;
              end
            end else begin
              presc_reg <= presc_reg + 16'd1;
            end
          end
          ST_BLANK: begin
            if (bcnt_reg == BLANK_LAST) begin
              state_reg   <= ST_SHOW;
              bcnt_reg    <= 8'd0;
              presc_reg   <= 16'd0;
              sel_vld_reg <= 1'b1;
            end else begin
              bcnt_reg <= bcnt_reg + 8'd1;
            end
          end
          default: begin
            state_reg   <= ST_IDLE;
            sel_vld_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel        = sel_reg;
  assign sel_vld    = sel_vld_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_scan_sel_gen.sv
// ---------------------------------------------------------------------------
// tb_scan_sel_gen
//   Four scanner configurations driven from common inputs:
//     A: DIV=4 BLANK=1 NDIG=8   B: DIV=4 BLANK=0 NDIG=8
//     C: DIV=4 BLANK=1 NDIG=5   D: DIV=3 BLANK=2 NDIG=1
//   A time-based model (cycles elapsed within the current digit period)
//   predicts every output of every instance each cycle. A hand-derived
//   vector table and a few directed sequences cover configuration A.
// ---------------------------------------------------------------------------
module tb_scan_sel_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic dir = 1'b0;

  logic [2:0] sel_a, sel_b, sel_c, sel_d;
  logic       vld_a, vld_b, vld_c, vld_d;
  logic       fd_a, fd_b, fd_c, fd_d;

  always #5 clk = ~clk;

  scan_sel_gen #(.DIV(4), .BLANK(1), .NDIG(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
    .sel(sel_a), .sel_vld(vld_a), .frame_done(fd_a));
  scan_sel_gen #(.DIV(4), .BLANK(0), .NDIG(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
    .sel(sel_b), .sel_vld(vld_b), .frame_done(fd_b));
  scan_sel_gen #(.DIV(4), .BLANK(1), .NDIG(5)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
    .sel(sel_c), .sel_vld(vld_c), .frame_done(fd_c));
  scan_sel_gen #(.DIV(3), .BLANK(2), .NDIG(1)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir),
    .sel(sel_d), .sel_vld(vld_d), .frame_done(fd_d));

  logic [4:0] got [4];
  assign got[0] = {sel_a, vld_a, fd_a};
  assign got[1] = {sel_b, vld_b, fd_b};
  assign got[2] = {sel_c, vld_c, fd_c};
  assign got[3] = {sel_d, vld_d, fd_d};

  int pdiv   [4] = '{4, 4, 4, 3};
  int pblank [4] = '{1, 0, 1, 2};
  int pndig  [4] = '{8, 8, 5, 1};

  // Model: active scanner plus cycles elapsed since the digit period began.
  typedef struct {
    bit active;
    int t;
    int sel;
    bit fd;
  } mst_t;

  mst_t ms [4];

  int checks = 0;
  int errors = 0;

  function automatic mst_t mstep(mst_t m, int div, int blank, int ndig,
                                 bit e, bit c, bit d);
    mst_t r;
    r = m;
    r.fd = 1'b0;
    if (c) begin
      r.sel = 0;
      r.t = 0;
      r.active = e;
    end else if (!e) begin
      r.active = 1'b0;
      r.t = 0;
    end else if (!m.active) begin
      r.active = 1'b1;
      r.t = 0;
    end else begin
      r.t = m.t + 1;
      if (r.t == div) begin
        if (d) begin
          r.fd = (m.sel == 0);
          r.sel = (m.sel + ndig - 1) % ndig;
        end else begin
          r.fd = (m.sel + 1 == ndig);
          r.sel = (m.sel + 1) % ndig;
        end
      end
      if (r.t == div + blank) r.t = 0;
    end
    return r;
  endfunction

  function automatic logic [4:0] mexp(mst_t m, int div);
    logic [31:0] s;
    s = m.sel;
    return {s[2:0], (m.active && (m.t < div)), m.fd};
  endfunction

  task automatic check_all(input string tag);
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      e = mexp(ms[i], pdiv[i]);
      checks++;
      if (got[i] !== e) begin
        errors++;
        $display("FAIL model_%s inst%0d t=%0t got sel=%0d vld=%0b fd=%0b exp sel=%0d vld=%0b fd=%0b",
                 tag, i, $time, got[i][4:2], got[i][1], got[i][0], e[4:2], e[1], e[0]);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      ms[i] = mstep(ms[i], pdiv[i], pblank[i], pndig[i], en, clr, dir);
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) ms[i] = '{1'b0, 0, 0, 1'b0};
    #1;
    check_all("async_reset");
    checks++;
    if ({sel_a, vld_a, fd_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got sel=%0d vld=%0b fd=%0b exp 0 0 0", sel_a, vld_a, fd_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed vectors for configuration A: optional reset, inputs held for n
  // edges, then expected A outputs.
  typedef struct {
    int rst;
    int en;
    int clr;
    int dir;
    int n;
    int sel;
    int vld;
    int fd;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst en clr dir  n  sel vld fd
    // Up scan from reset, one frame, then down scan and dir mid-digit.
    tbl.push_back('{1, 1, 0, 0,  1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  3, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  1, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 0,  1, 1, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 30, 7, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  4, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0,  1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 1,  4, 7, 0, 1});
    tbl.push_back('{0, 1, 0, 1,  1, 7, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  2, 7, 1, 0});
    tbl.push_back('{0, 1, 0, 1,  2, 6, 0, 0});
    tbl.push_back('{0, 0, 0, 1,  1, 6, 0, 0});
    tbl.push_back('{0, 0, 0, 1,  3, 6, 0, 0});
    tbl.push_back('{0, 1, 0, 1,  1, 6, 1, 0});
    tbl.push_back('{0, 1, 0, 1,  3, 6, 1, 0});
    tbl.push_back('{0, 1, 0, 1,  1, 5, 0, 0});
    tbl.push_back('{0, 1, 1, 0,  1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  3, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  1, 1, 0, 0});
    // en dropped at prescaler=2 on sel=3, re-raised 5 cycles later.
    tbl.push_back('{1, 1, 0, 0, 18, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 0,  1, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  4, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 0,  1, 3, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  3, 3, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  1, 4, 0, 0});
    // clr on the edge that would advance 7 -> 0.
    tbl.push_back('{1, 1, 0, 0, 36, 7, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  3, 7, 1, 0});
    tbl.push_back('{0, 1, 1, 0,  1, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  3, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0,  1, 1, 0, 0});

    for (int i = 0; i < 4; i++) ms[i] = '{1'b0, 0, 0, 1'b0};
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst != 0) do_reset();
      en  = (tbl[k].en != 0);
      clr = (tbl[k].clr != 0);
      dir = (tbl[k].dir != 0);
      repeat (tbl[k].n) tick("tbl");
      checks++;
      if ({sel_a, vld_a, fd_a} !== {3'(tbl[k].sel), tbl[k].vld != 0, tbl[k].fd != 0}) begin
        errors++;
        $display("FAIL vec%0d got sel=%0d vld=%0b fd=%0b exp sel=%0d vld=%0d fd=%0d",
                 k, sel_a, vld_a, fd_a, tbl[k].sel, tbl[k].vld, tbl[k].fd);
      end
    end

    // Reset pulsed between edges while A is blanking; IDLE until en sampled.
    begin
      int w;
      en = 1'b1;
      clr = 1'b0;
      dir = 1'b0;
      w = 0;
      while (!(ms[0].active && ms[0].t >= pdiv[0]) && w < 20) begin
        tick("to_blank");
        w++;
      end
      checks++;
      if (w >= 20) begin
        errors++;
        $display("FAIL reach_blank got %0d cycles exp < 20", w);
      end
      do_reset();
      en = 1'b0;
      repeat (5) tick("idle_hold");
      checks++;
      if ({sel_a, vld_a} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_hold got sel=%0d vld=%0b exp sel=0 vld=0", sel_a, vld_a);
      end
      en = 1'b1;
      tick("resume");
      checks++;
      if ({sel_a, vld_a} !== 4'b0001) begin
        errors++;
        $display("FAIL first_show got sel=%0d vld=%0b exp sel=0 vld=1", sel_a, vld_a);
      end
    end

    // Randomized run, all four configurations checked against the model.
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 99) < 95);
      clr = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 5) dir = ~dir;
      if ($urandom_range(0, 799) == 0) do_reset();
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 Parameter DIV, default 1000: clock cycles each digit is shown; legal range 1..65535.
REQ-002 Parameter BLANK, default 2: blanking cycles between digits; legal range 0..255.
REQ-003 Parameter NDIG, default 8: number of digits scanned; legal range 1..8.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: scan enable; sampled each edge.
REQ-007 Port clr, input, 1: synchronous restart from digit 0.
REQ-008 Port dir, input, 1: scan direction; 0 = up, 1 = down; sampled only at advance.
REQ-009 Port sel, output, 3: current digit index, drives the downstream 3-to-8 decoder select d[2:0].
REQ-010 Port sel_vld, output, 1: high when the digit selected by sel may be driven; low means all digits blanked.
REQ-011 Port frame_done, output, 1: one-cycle pulse on scan wrap-around.

Function
REQ-012 States: IDLE, SHOW, BLANK; state, prescaler (16 bit) and blank counter (8 bit) shall be registered.
REQ-013 IDLE: sel_vld=0, sel held; en=1 -> SHOW next edge with prescaler=0.
REQ-014 SHOW: sel_vld=1; prescaler increments each edge; on the edge where prescaler==DIV-1 the block shall advance sel, clear prescaler, and enter BLANK (BLANK>0) or remain in SHOW (BLANK==0).
REQ-015 SHOW shall therefore last exactly DIV cycles per digit; full digit period = DIV+BLANK cycles; frame = NDIG*(DIV+BLANK) cycles.
REQ-016 BLANK: sel_vld=0, sel already shows next digit; blank counter runs 0..BLANK-1, then SHOW with prescaler=0.
REQ-017 Advance, dir=0: sel = (sel==NDIG-1) ? 0 : sel+1.
REQ-018 Advance, dir=1: sel = (sel==0) ? NDIG-1 : sel-1.
REQ-019 frame_done shall be 1 in the cycle after the advancing edge exactly when that advance wrapped (NDIG-1->0 up, 0->NDIG-1 down); 0 otherwise.
REQ-020 NDIG=1: every advance wraps; sel stays 0 and frame_done pulses once per digit period.
REQ-021 en=0 in SHOW or BLANK: next edge -> IDLE, counters cleared, sel held, no advance, no frame_done; re-enable resumes SHOW on held sel.
REQ-022 clr=1: next edge sel=0, counters cleared, frame_done=0, state = en ? SHOW : IDLE; clr overrides a coincident advance.
REQ-023 sel shall never take a value >= NDIG.
REQ-024 Outputs shall be registered; no combinational path from inputs to outputs.

Reset
REQ-025 rst_n=0 shall immediately force state=IDLE, sel=0, sel_vld=0, frame_done=0, both counters=0, independent of clk.
REQ-026 After rst_n release, first SHOW entry requires en=1 sampled on a rising edge.
REQ-027 Reset asserted mid-SHOW or mid-BLANK shall abandon the digit; no frame_done is produced.

Verification (DIV=4, BLANK=1, NDIG=8 unless stated)
REQ-028 Reset release, en=1, dir=0 -> sel 0,1,..,7,0; sel_vld high 4 cycles, low 1 cycle per digit; frame_done single pulse after 7->0, 40 cycles per frame.
REQ-029 dir=1 from sel=0 -> sel 7,6,..,0; frame_done after 0->7; dir toggled mid-digit takes effect only at next advance.
REQ-030 BLANK=0 -> sel_vld constantly 1 after first SHOW; sel changes every 4 cycles.
REQ-031 en dropped at prescaler=2 with sel=3 -> next cycle sel_vld=0, sel=3; en raised 5 cycles later -> sel=3 shown full 4 cycles before advancing to 4.
REQ-032 clr on the advancing edge with sel=7 -> sel=0, frame_done=0, fresh 4-cycle SHOW; NDIG=5 run -> sel never exceeds 4, frame = 25 cycles.
REQ-033 rst_n pulsed low between clock edges during BLANK -> outputs zero immediately, IDLE held until en sampled.
